// File: rtl/lfsr_result_fifo.sv
// lfsr_result_fifo: buffers sampled LFSR words in a FWFT FIFO and flags lockup/stuck/overflow conditions.
module lfsr_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     zero_seen,
  output logic                     stuck_seen,
  input  logic                     clr_flags,
  output logic [CNT_W-1:0]         sample_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] prev_data;
  logic prev_vld, push, pop, ovf_set, zero_set, stuck_set;
  always_comb begin
    full = level == (AW+1)'(DEPTH);
    empty = level == '0;
    out_valid = ~empty;
    out_data = out_valid ? mem[rd_ptr] : '0;
    pop = out_valid & out_ready;
    push = in_valid & (~full | pop);
    ovf_set = in_valid & full & ~pop;
    zero_set = in_valid & (in_data == '0);
    stuck_set = in_valid & prev_vld & (in_data == prev_data);
  end
  always_ff @(posedge clk)
    if (push & ~rst) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      sample_cnt <= '0;
      overflow <= 1'b0;
      zero_seen <= 1'b0;
      stuck_seen <= 1'b0;
      prev_vld <= 1'b0;
      prev_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push) sample_cnt <= sample_cnt + CNT_W'(1);
      level <= (push & ~pop) ? level + (AW+1)'(1) : (pop & ~push) ? level - (AW+1)'(1) : level;
      // a coincident set condition beats the clear
      overflow <= ovf_set | (overflow & ~clr_flags);
      zero_seen <= zero_set | (zero_seen & ~clr_flags);
      stuck_seen <= stuck_set | (stuck_seen & ~clr_flags);
      if (in_valid) begin
        prev_data <= in_data;
        prev_vld <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lfsr_result_fifo.sv
// tb_lfsr_result_fifo: directed stimulus checked against a queue-based model every cycle.
module tb_lfsr_result_fifo;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, clr_flags = 0;
  logic [31:0] in_data = 0, out_data, sample_cnt;
  logic out_valid, full, empty, overflow, zero_seen, stuck_seen;
  logic [3:0] level;
  int pass_cnt = 0, total = 0;
  bit started = 0;
  logic [31:0] q [$];
  logic [31:0] m_cnt, m_prev;
  logic m_ovf, m_zs, m_ss, m_pv;

  lfsr_result_fifo #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .zero_seen(zero_seen), .stuck_seen(stuck_seen), .clr_flags(clr_flags),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else pass_cnt++;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = 0; m_ovf = 0; m_zs = 0; m_ss = 0; m_pv = 0; m_prev = 0;
    end else begin
      automatic bit p = q.size() > 0 && out_ready;
      automatic bit w = in_valid && (q.size() < DEPTH || p);
      automatic bit os = in_valid && !w;
      automatic bit zs = in_valid && in_data == 0;
      automatic bit ss = in_valid && m_pv && in_data == m_prev;
      if (p) void'(q.pop_front());
      if (w) begin q.push_back(in_data); m_cnt++; end
      m_ovf = os | (m_ovf & ~clr_flags);
      m_zs = zs | (m_zs & ~clr_flags);
      m_ss = ss | (m_ss & ~clr_flags);
      if (in_valid) begin m_prev = in_data; m_pv = 1; end
    end
  end

  always @(negedge clk) if (started) begin
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_data", out_data, q.size() > 0 ? q[0] : 32'h0);
    chk("level", 32'(level), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("zero_seen", 32'(zero_seen), 32'(m_zs));
    chk("stuck_seen", 32'(stuck_seen), 32'(m_ss));
    chk("sample_cnt", sample_cnt, m_cnt);
  end

  task automatic step(input logic r, input logic iv, input logic [31:0] d, input logic ord, input logic clr);
    rst = r; in_valid = iv; in_data = d; out_ready = ord; clr_flags = clr;
    @(posedge clk); #1;
    rst = 0; in_valid = 0; out_ready = 0; clr_flags = 0;
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    started = 1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cnt", sample_cnt, 0);
    step(0, 1, 32'h1234FADC, 0, 0);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", out_data, 32'h1234FADC);
    chk("t1_level", 32'(level), 1);
    chk("t1_cnt", sample_cnt, 1);
    step(0, 0, 0, 1, 0);
    chk("t1_empty", 32'(empty), 1);
    chk("t1_data0", out_data, 0);

    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 32'(i), 0, 0);
      if (i == 8) chk("t2_full8", 32'(full), 1);
      if (i == 9) chk("t2_ovf9", 32'(overflow), 1);
    end
    chk("t2_level", 32'(level), 8);
    chk("t2_cnt", sample_cnt, 8);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", out_data, 32'(i));
      step(0, 0, 0, 1, 0);
    end
    for (int i = 11; i <= 14; i++) step(0, 1, 32'(i), 0, 0);
    for (int i = 11; i <= 14; i++) begin
      chk("t2_wrap", out_data, 32'(i));
      step(0, 0, 0, 1, 0);
    end

    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) step(0, 1, 32'(100 + i), 0, 0);
    step(0, 1, 32'hDEADBEEF, 1, 0);
    chk("t3_ovf", 32'(overflow), 0);
    chk("t3_level", 32'(level), 8);
    chk("t3_head", out_data, 32'd102);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("t3_last", out_data, 32'hDEADBEEF);
      step(0, 0, 0, 1, 0);
    end

    step(0, 1, 0, 0, 0);
    chk("t4_zero", 32'(zero_seen), 1);
    step(0, 0, 0, 0, 1);
    chk("t4_clr", 32'(zero_seen), 0);
    step(0, 1, 0, 0, 1);
    chk("t4_setwins", 32'(zero_seen), 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);

    step(0, 1, 32'h5D9FAD13, 0, 0);
    step(0, 1, 32'h5D9FAD13, 0, 0);
    chk("t5_stuck", 32'(stuck_seen), 1);
    for (int i = 0; i < 6; i++) step(0, 1, 32'(200 + i), 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t5_clr", 32'(stuck_seen), 0);
    step(0, 1, 32'h5D9FAD13, 0, 0);
    step(0, 1, 32'h5D9FAD13, 0, 0);
    chk("t5_stuck_full", 32'(stuck_seen), 1);
    chk("t5_ovf", 32'(overflow), 1);
    chk("t5_level", 32'(level), 8);

    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 32'(300 + i), 0, 0);
    step(0, 1, 0, 0, 0);
    chk("t6_pre_level", 32'(level), 5);
    chk("t6_pre_zero", 32'(zero_seen), 1);
    step(1, 1, 32'h77, 1, 0);
    chk("t6_level", 32'(level), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_zero", 32'(zero_seen), 0);
    chk("t6_cnt", sample_cnt, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_nostore", 32'(level), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/lfsr_result_fifo.md
Name: lfsr_result_fifo

Overview:
- Downstream capture stage for the LFSR_MultiStage output.
- Samples `lfsr_out` whenever the producer flags a valid word and buffers it in a small FIFO. A bus-side or bench-side consumer drains the FIFO through a valid/ready handshake.
- Monitors the incoming stream for LFSR failure signatures (all-zero lockup, stuck/repeated value) and holds sticky status flags for software readback via the CSR space.

Parameters:
- DATA_W, 32: width of the LFSR word.
- DEPTH, 8: FIFO entries. Must be a power of two, at least 2.
- CNT_W, 32: width of the accepted-sample counter.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer has a new LFSR word this cycle.
- in_data  in  DATA_W  LFSR word (connects to `lfsr_out`).
- out_valid  out  1  FIFO head word available.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  DATA_W  FIFO head word.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky: a valid input was dropped because the FIFO was full.
- zero_seen  out  1  sticky: an input word equal to 0 was sampled.
- stuck_seen  out  1  sticky: two consecutive sampled words were equal.
- clr_flags  in  1  clears all three sticky flags.
- sample_cnt  out  CNT_W  count of words written into the FIFO; wraps modulo 2^CNT_W.

Behaviour:
- **Reset.** The following are synchronous on `rst`=1 at a rising edge:
  - wr_ptr, rd_ptr, level and sample_cnt are 0.
  - overflow, zero_seen and stuck_seen are 0; prev_vld is 0.
  - empty=1, full=0, out_valid=0, out_data=0.
  - Memory contents are don't-care.
- **Reset mid-operation.** `rst` discards all buffered data at the next edge. Input and output handshakes in that cycle are ignored.
- **Push.** push = in_valid & ~full_eff, where full_eff = full & ~pop.
  - A push writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
  - A push increments sample_cnt; it wraps from all-ones to 0.
- **Pop.** pop = out_valid & out_ready. A pop increments rd_ptr modulo DEPTH.
- **Output.**
  - out_valid = ~empty.
  - out_data = mem[rd_ptr] when out_valid, else 0 (first-word fall-through).
  - Write-to-out_valid latency is 1 cycle: a word pushed at edge N is visible after edge N.
- **Level update.** level +1 on push only, -1 on pop only, unchanged on push & pop.
- **Full with pop.** When full, a simultaneous pop and in_valid are both accepted; level stays DEPTH.
- **Empty with in_valid.** No pop is possible (out_valid=0); the push is accepted.
- **Overflow.** in_valid & full & ~pop sets overflow; the word is dropped and sample_cnt is not incremented.
- **Monitor.** The monitor sees every `in_valid` word, including dropped ones.
  - zero_seen is set when in_valid & (in_data == 0).
  - stuck_seen is set when in_valid & prev_vld & (in_data == prev_data).
  - On in_valid: prev_data <= in_data, prev_vld <= 1.
- **Flag clear.** clr_flags clears overflow, zero_seen and stuck_seen. If a set condition coincides with clr_flags, set wins. clr_flags does not affect FIFO contents, sample_cnt or prev_data.
- **Out-of-range.** out_ready while empty has no effect.
- **Ordering.** Strict FIFO order is preserved across pointer wrap-around.

Test Plan:
1. **Reset values, single word.**
   - Stimulus: reset; check all outputs at reset values; push 32'h1234FADC for one cycle with out_ready=0.
   - Required: next cycle out_valid=1, out_data=32'h1234FADC, level=1, sample_cnt=1; then out_ready=1 for one cycle gives empty=1, out_data=0.
2. **Fill, overflow, wrap.**
   - Stimulus: push 10 distinct words (1..10) back-to-back with out_ready=0.
   - Required: full=1 after 8 pushes; overflow=1 after the 9th; level=8; sample_cnt=8. Draining returns 1..8 in order. Then push 11..14 and drain 11..14 (pointer wrap).
3. **Full with simultaneous push/pop.**
   - Stimulus: with the FIFO full, assert in_valid=1 (data 32'hDEADBEEF) and out_ready=1 in the same cycle.
   - Required: overflow stays 0, level stays 8, the head advances, and 32'hDEADBEEF is the last word drained.
4. **Zero lockup detection.**
   - Stimulus: push 32'h00000000.
   - Required: zero_seen=1 next cycle. Asserting clr_flags alone clears it. Asserting clr_flags in the same cycle as another zero push leaves zero_seen=1.
5. **Stuck detection, including dropped words.**
   - Stimulus: push 32'h5D9FAD13 twice in consecutive valid cycles.
   - Required: stuck_seen=1. Repeat with the FIFO full (both words dropped): stuck_seen still sets, overflow=1.
6. **Reset mid-stream.**
   - Stimulus: with 5 words buffered and flags set, pulse rst for one cycle while in_valid=1 and out_ready=1.
   - Required: next cycle level=0, empty=1, out_valid=0, all flags 0, sample_cnt=0. No word from the reset cycle is stored.
